// File: rtl/pipeline2_decode.sv
// Instruction-decode stage: field split, 16-entry register file, load-use stall, ID/EX register.
// Optional write-first read bypass from write-back is enabled by defining DECODE_BYPASS_EN.
module pipeline2_decode #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 16,
  parameter int DATA_WIDTH  = 16,
  parameter logic [5:0] OP_NOP  = 6'h00,
  parameter logic [5:0] OP_LOAD = 6'h20
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [3:0]             wb_addr,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  output logic                   stall,
  output logic                   valid_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [5:0]             opcode_out,
  output logic [3:0]             rd_out,
  output logic [DATA_WIDTH-1:0]  rs_data,
  output logic [DATA_WIDTH-1:0]  rt_data,
  output logic [DATA_WIDTH-1:0]  imm_out,
  output logic                   mem_rd_out
);

  logic [5:0]            opcode;
  logic [3:0]            rd, rs, rt;
  logic [DATA_WIDTH-1:0] imm_ext;

  assign opcode  = instr[31:26];
  assign rd      = instr[25:22];
  assign rs      = instr[21:18];
  assign rt      = instr[17:14];
  assign imm_ext = {{(DATA_WIDTH-14){instr[13]}}, instr[13:0]};

  logic [DATA_WIDTH-1:0] regs_q [16];
  logic [DATA_WIDTH-1:0] regs_d [16];
  logic                  wb_hit;

  assign wb_hit = wb_en & (wb_addr != 4'd0);

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wb_hit) begin
      regs_d[wb_addr] = wb_data;
    end
    regs_d[0] = '0;
  end

  logic [DATA_WIDTH-1:0] rs_val, rt_val;

  always_comb begin
    rs_val = (rs == 4'd0) ? '0 : regs_q[rs];
    rt_val = (rt == 4'd0) ? '0 : regs_q[rt];
`ifdef DECODE_BYPASS_EN
    if (wb_hit && (wb_addr == rs)) rs_val = wb_data;
    if (wb_hit && (wb_addr == rt)) rt_val = wb_data;
`endif
  end

  logic                  valid_q, valid_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [5:0]            opcode_q, opcode_d;
  logic [3:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rs_data_q, rs_data_d;
  logic [DATA_WIDTH-1:0] rt_data_q, rt_data_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic                  mem_rd_q, mem_rd_d;

  // A load in ID/EX whose destination feeds this instruction must wait one cycle.
  assign stall = valid_q & mem_rd_q & (rd_q != 4'd0) & ((rd_q == rs) | (rd_q == rt))
                 & (opcode != OP_NOP) & ~flush;

  always_comb begin
    valid_d   = (opcode != OP_NOP);
    pc_d      = pc_in;
    opcode_d  = opcode;
    rd_d      = rd;
    rs_data_d = rs_val;
    rt_data_d = rt_val;
    imm_d     = imm_ext;
    mem_rd_d  = (opcode == OP_LOAD);
    if (flush || stall) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      opcode_d  = OP_NOP;
      rd_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      mem_rd_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      opcode_q  <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      mem_rd_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      mem_rd_q  <= mem_rd_d;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign valid_out  = valid_q;
  assign pc_out     = pc_q;
  assign opcode_out = opcode_q;
  assign rd_out     = rd_q;
  assign rs_data    = rs_data_q;
  assign rt_data    = rt_data_q;
  assign imm_out    = imm_q;
  assign mem_rd_out = mem_rd_q;

endmodule

// File: tb/tb_pipeline2_decode.sv
// Bench for pipeline2_decode: directed scenarios then randomized traffic against a reference model.
module tb_pipeline2_decode;

  logic        clk_in = 1'b0;
  logic        RST;
  logic [31:0] instr;
  logic [15:0] pc_in;
  logic        flush, wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        stall, valid_out, mem_rd_out;
  logic [15:0] pc_out, rs_data, rt_data, imm_out;
  logic [5:0]  opcode_out;
  logic [3:0]  rd_out;

  pipeline2_decode dut (
    .clk_in(clk_in), .RST(RST), .instr(instr), .pc_in(pc_in), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .valid_out(valid_out), .pc_out(pc_out), .opcode_out(opcode_out), .rd_out(rd_out),
    .rs_data(rs_data), .rt_data(rt_data), .imm_out(imm_out), .mem_rd_out(mem_rd_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [15:0] m_regs [16];
  logic        m_valid, m_mem;
  logic [15:0] m_pc, m_rs, m_rt, m_imm;
  logic [5:0]  m_op;
  logic [3:0]  m_rd;
  logic        m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] rt,
                                     input logic [13:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  // One clock: drive inputs, check stall mid-cycle, advance model, check registered outputs.
  task automatic step(input logic [31:0] i_instr, input logic [15:0] i_pc, input logic i_flush,
                      input logic i_wb_en, input logic [3:0] i_wb_addr,
                      input logic [15:0] i_wb_data, input logic i_rst);
    logic [5:0]  op;
    logic [3:0]  rd, rs, rt;
    logic [13:0] imm14;
    logic [15:0] rsv, rtv, ext;
    logic        wb_ok;
    instr = i_instr; pc_in = i_pc; flush = i_flush;
    wb_en = i_wb_en; wb_addr = i_wb_addr; wb_data = i_wb_data; RST = i_rst;
    op = i_instr[31:26]; rd = i_instr[25:22]; rs = i_instr[21:18]; rt = i_instr[17:14];
    imm14 = i_instr[13:0];
    ext = (imm14 >= 14'd8192) ? (16'(imm14) | 16'hC000) : 16'(imm14);
    m_stall = m_valid && (m_op == 6'h20) && (m_rd != 0) && (m_rd == rs || m_rd == rt)
              && (op != 6'h00) && !i_flush;
    wb_ok = i_wb_en && (i_wb_addr != 0);
    rsv = (rs == 0) ? 16'h0 : m_regs[rs];
    rtv = (rt == 0) ? 16'h0 : m_regs[rt];
`ifdef DECODE_BYPASS_EN
    if (wb_ok && i_wb_addr == rs) rsv = i_wb_data;
    if (wb_ok && i_wb_addr == rt) rtv = i_wb_data;
`endif
    @(negedge clk_in);
    check("stall", 32'(stall), 32'(m_stall));
    @(posedge clk_in);
    if (i_rst) begin
      for (int k = 0; k < 16; k++) m_regs[k] = 16'h0;
      {m_valid, m_mem, m_pc, m_op, m_rd, m_rs, m_rt, m_imm} = '0;
    end else begin
      if (wb_ok) m_regs[i_wb_addr] = i_wb_data;
      if (i_flush || m_stall) begin
        {m_valid, m_mem, m_pc, m_op, m_rd, m_rs, m_rt, m_imm} = '0;
      end else begin
        m_valid = (op != 6'h00); m_mem = (op == 6'h20); m_pc = i_pc; m_op = op;
        m_rd = rd; m_rs = rsv; m_rt = rtv; m_imm = ext;
      end
    end
    #1;
    check("valid_out",  32'(valid_out),  32'(m_valid));
    check("pc_out",     32'(pc_out),     32'(m_pc));
    check("opcode_out", 32'(opcode_out), 32'(m_op));
    check("rd_out",     32'(rd_out),     32'(m_rd));
    check("rs_data",    32'(rs_data),    32'(m_rs));
    check("rt_data",    32'(rt_data),    32'(m_rt));
    check("imm_out",    32'(imm_out),    32'(m_imm));
    check("mem_rd_out", 32'(mem_rd_out), 32'(m_mem));
  endtask

  initial begin
    logic [31:0] cur_instr;
    logic [15:0] cur_pc;
    logic [15:0] exp_byp;
    for (int k = 0; k < 16; k++) m_regs[k] = 16'h0;
    {m_valid, m_mem, m_pc, m_op, m_rd, m_rs, m_rt, m_imm} = '0;
    RST = 1'b1; instr = '0; pc_in = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    @(posedge clk_in); #1;

    // reset drops a concurrent write-back
    step(32'h0, 16'h0, 1'b0, 1'b1, 4'd3, 16'h0007, 1'b1);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_rs", 32'(rs_data), 32'h0);
    step(mk(6'h01, 4'd1, 4'd3, 4'd0, 14'h0), 16'd4, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("rst_r3_read", 32'(rs_data), 32'h0);

    step(32'h0, 16'h0, 1'b0, 1'b1, 4'd2, 16'h0012, 1'b0);
    step(32'h0, 16'h0, 1'b0, 1'b1, 4'd5, 16'h0034, 1'b0);
    step(mk(6'h01, 4'd4, 4'd2, 4'd5, 14'h3FFE), 16'd20, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("dec_valid", 32'(valid_out), 32'h1);
    check("dec_rs", 32'(rs_data), 32'h0012);
    check("dec_rt", 32'(rt_data), 32'h0034);
    check("dec_imm", 32'(imm_out), 32'hFFFE);
    check("dec_rd", 32'(rd_out), 32'h4);
    check("dec_pc", 32'(pc_out), 32'd20);

    // load-use: exactly one stall cycle, then the dependent instruction
    step(mk(6'h20, 4'd6, 4'd0, 4'd0, 14'h1), 16'd24, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    step(mk(6'h02, 4'd7, 4'd6, 4'd1, 14'h2), 16'd28, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("lu_stall", 32'(m_stall), 32'h1);
    check("lu_bubble", 32'(valid_out), 32'h0);
    step(mk(6'h02, 4'd7, 4'd6, 4'd1, 14'h2), 16'd28, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("lu_nostall", 32'(stall), 32'h0);
    check("lu_dep_op", 32'(opcode_out), 32'h02);
    check("lu_dep_pc", 32'(pc_out), 32'd28);

    // load to r0 never stalls
    step(mk(6'h20, 4'd0, 4'd0, 4'd0, 14'h1), 16'd32, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    step(mk(6'h02, 4'd7, 4'd0, 4'd1, 14'h2), 16'd36, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("r0load_stall", 32'(stall), 32'h0);
    check("r0load_valid", 32'(valid_out), 32'h1);

    // flush wins over a pending stall
    step(mk(6'h20, 4'd7, 4'd0, 4'd0, 14'h1), 16'd40, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    step(mk(6'h02, 4'd8, 4'd7, 4'd1, 14'h2), 16'd44, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
    check("fl_stall", 32'(stall), 32'h0);
    check("fl_bubble", 32'(valid_out), 32'h0);
    step(mk(6'h03, 4'd9, 4'd7, 4'd1, 14'h5), 16'd48, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("fl_next_op", 32'(opcode_out), 32'h03);
    check("fl_next_pc", 32'(pc_out), 32'd48);

    // same-cycle write-back vs. read of r2
`ifdef DECODE_BYPASS_EN
    exp_byp = 16'h00AA;
`else
    exp_byp = 16'h0012;
`endif
    step(mk(6'h01, 4'd1, 4'd2, 4'd0, 14'h0), 16'd52, 1'b0, 1'b1, 4'd2, 16'h00AA, 1'b0);
    check("bypass_rs", 32'(rs_data), 32'(exp_byp));

    step(32'h0, 16'h0, 1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0);
    step(mk(6'h01, 4'd1, 4'd0, 4'd0, 14'h0), 16'd56, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("r0_read", 32'(rs_data), 32'h0);

    // randomized traffic; fetch holds its instruction while stalled
    cur_instr = '0; cur_pc = '0;
    for (int n = 0; n < 400; n++) begin
      if (!m_stall || n == 0) begin
        logic [5:0] op;
        case ($urandom_range(0, 3))
          0: op = 6'h00;
          1, 2: op = 6'h20;
          default: op = 6'($urandom);
        endcase
        cur_instr = mk(op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                       4'($urandom_range(0, 7)), 14'($urandom));
        cur_pc = 16'($urandom);
      end
      step(cur_instr, cur_pc, ($urandom_range(0, 7) == 0), 1'($urandom),
           4'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
